// File: rtl/ham_rx_deser_14_pkg.sv
// rtl/ham_rx_deser_14_pkg.sv - shared constants and state encoding for the serial codeword receiver
package ham_rx_deser_14_pkg;

  localparam int RX_CW_W   = 14;
  localparam int RX_DATA_W = 10;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// rtl/rx_gap_timer.sv - inter-bit gap counter with a terminal pulse on the GAP_MAX-th idle cycle
module rx_gap_timer #(
  parameter int GAP_MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(GAP_MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  // expire fires combinationally on the increment that would reach GAP_MAX
  assign expire = en && !clear && (cnt_q == CNT_W'(GAP_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || expire) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ham_rx_deser_14.sv
// rtl/ham_rx_deser_14.sv - start/data/stop deserializer producing Hamming(14,10) codewords
module ham_rx_deser_14
  import ham_rx_deser_14_pkg::*;
#(
  parameter int CW_W    = RX_CW_W,
  parameter int GAP_MAX = 64,
  parameter int ERRC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_d,
  input  logic              bit_vld,
  output logic [CW_W-1:0]   code_o,
  output logic              code_vld,
  output logic              frame_err,
  output logic [ERRC_W-1:0] err_cnt,
  output logic              busy
);

  localparam int BCNT_W = $clog2(CW_W);

  rx_state_t         state_q, state_d;
  logic [CW_W-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CW_W-1:0]   code_q, code_d;
  logic              vld_d, err_d;
  logic [ERRC_W-1:0] errc_q, errc_d;
  logic              busy_q;
  logic              vld_q, err_q;
  logic              gap_clear, gap_expire;

  assign gap_clear = bit_vld || (state_q == ST_IDLE);

  rx_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (gap_clear),
    .en     (!gap_clear),
    .expire (gap_expire)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    code_d  = code_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bit_vld && (rx_d != LINE_IDLE)) begin
          state_d = ST_DATA;
          bcnt_d  = '0;
          shreg_d = '0;
        end
      end
      ST_DATA: begin
        if (gap_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bit_vld) begin
          shreg_d[bcnt_q] = rx_d;
          bcnt_d          = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(CW_W - 1)) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (gap_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bit_vld) begin
          // a bad stop bit returns to IDLE without treating the 0 as a new start
          state_d = ST_IDLE;
          if (rx_d == LINE_IDLE) begin
            code_d = shreg_q;
            vld_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    errc_d = errc_q;
    if (err_d && (errc_q != {ERRC_W{1'b1}})) begin
      errc_d = errc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign code_o    = code_q;
  assign code_vld  = vld_q;
  assign frame_err = err_q;
  assign err_cnt   = errc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ham_rx_deser_14.sv
// tb/tb_ham_rx_deser_14.sv - directed self-checking bench for ham_rx_deser_14
module tb_ham_rx_deser_14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_d = 1'b1;
  logic        bit_vld = 1'b0;
  logic [13:0] code_o;
  logic        code_vld, frame_err, busy;
  logic [7:0]  err_cnt;
  logic [13:0] s_code_o;
  logic        s_code_vld, s_frame_err, s_busy;
  logic [1:0]  s_err_cnt;

  int total = 0;
  int bad = 0;
  int vld_pulses = 0;
  int err_pulses = 0;
  logic last_vld, last_err, last_busy;

  always #5 clk = ~clk;

  ham_rx_deser_14 dut (
    .clk(clk), .rst(rst), .rx_d(rx_d), .bit_vld(bit_vld),
    .code_o(code_o), .code_vld(code_vld), .frame_err(frame_err),
    .err_cnt(err_cnt), .busy(busy)
  );

  ham_rx_deser_14 #(.ERRC_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rx_d(rx_d), .bit_vld(bit_vld),
    .code_o(s_code_o), .code_vld(s_code_vld), .frame_err(s_frame_err),
    .err_cnt(s_err_cnt), .busy(s_busy)
  );

  always @(posedge clk) begin
    #1;
    if (code_vld) vld_pulses++;
    if (frame_err) err_pulses++;
  end

  task automatic send_bit(input logic b, input int sp);
    rx_d = b;
    bit_vld = 1'b1;
    @(negedge clk);
    last_vld = code_vld;
    last_err = frame_err;
    last_busy = busy;
    bit_vld = 1'b0;
    rx_d = 1'b1;
    repeat (sp - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [13:0] w, input logic stop_b, input int sp);
    send_bit(1'b0, sp);
    for (int i = 0; i < 14; i++) send_bit(w[i], sp);
    send_bit(stop_b, sp);
  endtask

  task automatic test_reset();
    int v0, e0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (code_o !== 14'h0) begin bad++; $display("FAIL reset_code got=%h want=0", code_o); end
    total++; if (err_cnt !== 8'h0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_cnt); end
    total++; if ({code_vld, frame_err, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {code_vld, frame_err, busy}); end
    v0 = vld_pulses; e0 = err_pulses;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1, 1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy bit=%0d got=%b want=0", i, busy); end
    end
    @(negedge clk);
    total++; if (vld_pulses != v0 || err_pulses != e0) begin bad++; $display("FAIL idle_pulses got vld=%0d err=%0d want 0 0", vld_pulses - v0, err_pulses - e0); end
    total++; if (code_o !== 14'h0) begin bad++; $display("FAIL idle_code got=%h want=0", code_o); end
  endtask

  task automatic check_good(input string nm, input logic [13:0] w, input int v0);
    total++; if (last_vld !== 1'b1 || last_err !== 1'b0) begin bad++; $display("FAIL %s_strobe got vld=%b err=%b want 1 0", nm, last_vld, last_err); end
    total++; if (code_o !== w) begin bad++; $display("FAIL %s_code got=%h want=%h", nm, code_o, w); end
    total++; if (vld_pulses - v0 != 1) begin bad++; $display("FAIL %s_pulses got=%0d want=1", nm, vld_pulses - v0); end
  endtask

  task automatic test_good_frame();
    int v0;
    v0 = vld_pulses;
    send_frame(14'h1A5C, 1'b1, 4);
    check_good("good", 14'h1A5C, v0);
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL good_errcnt got=%0d want=0", err_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b want=0", busy); end
  endtask

  task automatic test_bad_stop();
    int v0;
    v0 = vld_pulses;
    send_frame(14'h1A5C, 1'b0, 4);
    total++; if (last_err !== 1'b1 || last_vld !== 1'b0) begin bad++; $display("FAIL badstop_strobe got err=%b vld=%b want 1 0", last_err, last_vld); end
    total++; if (code_o !== 14'h1A5C) begin bad++; $display("FAIL badstop_code got=%h want=1a5c", code_o); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL badstop_errcnt got=%0d want=1", err_cnt); end
    total++; if (last_busy !== 1'b0 || vld_pulses != v0) begin bad++; $display("FAIL badstop_idle got busy=%b vld=%0d want 0 0", last_busy, vld_pulses - v0); end
    v0 = vld_pulses;
    send_frame(14'h0001, 1'b1, 3);
    check_good("after_bad", 14'h0001, v0);
  endtask

  task automatic test_timeout();
    int v0, seen;
    send_bit(1'b0, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy_before got=%b want=1", busy); end
    seen = 0;
    for (int i = 1; i <= 100 && seen == 0; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) seen = i;
    end
    total++; if (seen != 64) begin bad++; $display("FAIL to_latency got=%0d want=64", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy_after got=%b want=0", busy); end
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL to_errcnt got=%0d want=2", err_cnt); end
    total++; if (code_o !== 14'h0001) begin bad++; $display("FAIL to_code got=%h want=0001", code_o); end
    v0 = vld_pulses;
    send_frame(14'h3FFF, 1'b1, 2);
    check_good("after_to", 14'h3FFF, v0);
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = vld_pulses;
    send_frame(14'h2AAA, 1'b1, 1);
    check_good("b2b_a", 14'h2AAA, v0);
    v0 = vld_pulses;
    send_frame(14'h1555, 1'b1, 1);
    check_good("b2b_b", 14'h1555, v0);
    v0 = vld_pulses; e0 = err_pulses;
    send_bit(1'b0, 1);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({code_vld, frame_err, busy} !== 3'b000) begin bad++; $display("FAIL midrst_flags got=%b want=000", {code_vld, frame_err, busy}); end
    total++; if (code_o !== 14'h0 || err_cnt !== 8'd0) begin bad++; $display("FAIL midrst_regs got code=%h cnt=%0d want 0 0", code_o, err_cnt); end
    total++; if (vld_pulses != v0 || err_pulses != e0) begin bad++; $display("FAIL midrst_pulses got vld=%0d err=%0d want 0 0", vld_pulses - v0, err_pulses - e0); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s [5];
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3; exp_s[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      send_frame(14'h0F0F, 1'b0, 2);
      total++; if (s_err_cnt !== exp_s[i]) begin bad++; $display("FAIL sat_cnt frame=%0d got=%0d want=%0d", i, s_err_cnt, exp_s[i]); end
      total++; if (err_cnt !== 8'(i + 1)) begin bad++; $display("FAIL wide_cnt frame=%0d got=%0d want=%0d", i, err_cnt, i + 1); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_timeout();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
